// File: rtl/eth_tx_framer.sv
// eth_tx_framer: byte-wide Ethernet MAC transmit framer (preamble, SFD, data, pad, FCS, IFG)
//
// Build option: define ETH_TX_PAD_EN to zero-pad frames shorter than MIN_LEN bytes.
// Without it the PAD state and byte counter are absent and short frames go out unpadded.
//
// eth_tx_framer ports:
//   clk                             sole clock, one wire byte per cycle
//   rst_n                           asynchronous active-low reset
//   s_data/s_valid/s_last/s_ready   frame byte stream (destination MAC through payload end)
//   tx_data/tx_en/tx_er             registered PHY-side byte interface
//   busy                            framer is not idle
// eth_crc32 ports:
//   clk, rst (async, active-high), init_i (sync restart), en_i, data_i, crc_o (reflected state)

module eth_crc32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);
    logic [31:0] crc_d;
    // LSB-first (reflected) CRC-32, polynomial 0xEDB88320, one byte per enabled cycle
    always_comb begin
        crc_d = crc_o;
        for (int i = 0; i < 8; i++)
            crc_d = (crc_d[0] ^ data_i[i]) ? (crc_d >> 1) ^ 32'hEDB88320 : crc_d >> 1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_o <= '1;
        else if (init_i) crc_o <= '1;
        else if (en_i) crc_o <= crc_d;
    end
endmodule

module eth_tx_framer #(
    parameter int MIN_LEN = 60,
    parameter int IFG_LEN = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy
);
    localparam int TW = $clog2(IFG_LEN + 8);
    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
`ifdef ETH_TX_PAD_EN
        PAD,
`endif
        FCS,
        IFG
    } state_t;
    state_t state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic tx_en_q, tx_en_d;
    logic tx_er_q, tx_er_d;
    logic [31:0] crc;
    logic crc_en;
    logic [7:0] crc_data;
`ifdef ETH_TX_PAD_EN
    logic [5:0] cnt_q, cnt_d, cnt_inc;
    // count including the byte being loaded this cycle, saturating at MIN_LEN
    assign cnt_inc = (cnt_q == 6'(MIN_LEN)) ? cnt_q : cnt_q + 6'd1;
    assign cnt_d = (state_q == SFD) ? '0 : crc_en ? cnt_inc : cnt_q;
    assign crc_en = (state_q == DATA && s_valid) || state_q == PAD;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    logic unused_min_len;
    assign unused_min_len = ^MIN_LEN;
    assign crc_en = state_q == DATA && s_valid;
`endif
    assign crc_data = (state_q == DATA) ? s_data : 8'h00;
    eth_crc32 u_crc (
        .clk    (clk),
        .rst    (!rst_n),
        .init_i (state_q == SFD),
        .en_i   (crc_en),
        .data_i (crc_data),
        .crc_o  (crc)
    );
    // per-state cycle timer, restarted on every state change
    assign tmr_d = (state_d != state_q) ? '0 : tmr_q + TW'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            tx_er_q   <= tx_er_d;
        end
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (s_valid) state_d = PRE;
            PRE:  if (tmr_q == TW'(5)) state_d = SFD;
            SFD:  state_d = DATA;
            DATA: begin
                if (!s_valid) state_d = IFG;
`ifdef ETH_TX_PAD_EN
                else if (s_last) state_d = (cnt_inc < 6'(MIN_LEN)) ? PAD : FCS;
            end
            PAD:  if (cnt_inc == 6'(MIN_LEN)) state_d = FCS;
`else
                else if (s_last) state_d = FCS;
            end
`endif
            FCS:  if (tmr_q == TW'(3)) state_d = IFG;
            IFG:  if (tmr_q == TW'(IFG_LEN - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // PAD and any unreachable encoding fall to the default: zero byte with tx_en high
    always_comb begin
        tx_data_d = 8'h00;
        tx_en_d   = 1'b1;
        tx_er_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_en_d   = s_valid;
                tx_data_d = s_valid ? 8'h55 : 8'h00;
            end
            PRE:  tx_data_d = 8'h55;
            SFD:  tx_data_d = 8'hD5;
            DATA: begin
                tx_data_d = s_valid ? s_data : 8'h00;
                tx_er_d   = !s_valid;
            end
            FCS:  tx_data_d = ~crc[{tmr_q[1:0], 3'b000} +: 8];
            IFG:  tx_en_d = 1'b0;
            default: tx_data_d = 8'h00;
        endcase
    end
    assign s_ready = state_q == DATA;
    assign busy    = state_q != IDLE;
    assign tx_data = tx_data_q;
    assign tx_en   = tx_en_q;
    assign tx_er   = tx_er_q;
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: table-driven frames with a wire-byte scoreboard plus multi-cycle corner sequences
module tb_eth_tx_framer;
`ifdef ETH_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    logic clk, rst_n;
    logic [7:0] s_data;
    logic s_valid, s_last, s_ready;
    logic [7:0] tx_data;
    logic tx_en, tx_er, busy;

    eth_tx_framer #(.MIN_LEN(60), .IFG_LEN(12)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .tx_data (tx_data),
        .tx_en   (tx_en),
        .tx_er   (tx_er),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    kind;     // 0 ramp, 1 ASCII "123456789", 2 constant 0xAB, 3 random
        int    len;
        int    drop_at;  // payload index where s_valid drops, -1 for none
        int    exp_run;  // expected consecutive tx_en cycles
    } vec_t;

    vec_t vecs[7];
    logic [7:0] pl[$];
    logic [8:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int run = 0, gap = 0, last_run = 0, last_gap = 0, byte_idx = 0;
    logic [8:0] mon_e;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] crc32(input logic [7:0] b[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[k])
            for (int j = 0; j < 8; j++)
                if (c[0] ^ b[k][j]) c = (c >> 1) ^ 32'hEDB88320;
                else c = c >> 1;
        return ~c;
    endfunction

    // wire-side scoreboard: every tx_en cycle pops one expected {tx_er, tx_data}
    always @(negedge clk) begin
        if (tx_en) begin
            if (run == 0) last_gap = gap;
            run++;
            gap = 0;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wire byte %0d: got er=%b data=%h, want no byte", byte_idx, tx_er, tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({tx_er, tx_data} !== mon_e) begin
                    errors++;
                    $display("FAIL wire byte %0d: got er=%b data=%h, want er=%b data=%h",
                             byte_idx, tx_er, tx_data, mon_e[8], mon_e[7:0]);
                end
            end
            byte_idx++;
        end else begin
            if (run != 0) last_run = run;
            run = 0;
            gap++;
        end
    end

    task automatic make_payload(input int kind, input int len);
        string s = "123456789";
        pl.delete();
        for (int i = 0; i < len; i++)
            case (kind)
                0: pl.push_back(8'(i));
                1: pl.push_back(s[i]);
                2: pl.push_back(8'hAB);
                default: pl.push_back(8'($urandom_range(255)));
            endcase
    endtask

    task automatic expect_frame(input int drop_at, input bit fcs_const);
        logic [7:0] body[$];
        logic [31:0] c;
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        if (drop_at >= 0) begin
            for (int i = 0; i < drop_at; i++) exp_q.push_back({1'b0, pl[i]});
            exp_q.push_back({1'b1, 8'h00});
            return;
        end
        body = pl;
        if (PAD) while (body.size() < 60) body.push_back(8'h00);
        foreach (body[i]) exp_q.push_back({1'b0, body[i]});
        c = fcs_const ? 32'hCBF43926 : crc32(body);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, c[8*i +: 8]});
    endtask

    task automatic send(input int drop_at, input int rst_at, input bit hold, input bit chk_rdy, input bit fcs_const);
        int i = 0;
        int n = pl.size();
        int w = 0;
        bit seen = 1'b0;
        bit took;
        bit ended = 1'b0;
        expect_frame(drop_at, fcs_const);
        for (int t = 0; t < 3000 && i < n; t++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = pl[i];
            s_last  = (i == n - 1);
            if (s_ready && !seen) begin
                seen = 1'b1;
                if (chk_rdy) chk("s_ready latency", w, 8);
            end
            if (!seen) w++;
            if (s_ready && i == drop_at) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                @(posedge clk);
                ended = 1'b1;
                break;
            end
            if (s_ready && i == rst_at) begin
                chk("pre-reset tx_en", tx_en, 1);
                #1 rst_n = 1'b0;
                #1;
                chk("async reset tx_en", tx_en, 0);
                chk("async reset tx_er", tx_er, 0);
                chk("async reset s_ready", s_ready, 0);
                chk("async reset busy", busy, 0);
                exp_q.delete();
                s_valid = 1'b0;
                s_last  = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                ended = 1'b1;
                break;
            end
            took = s_ready;
            @(posedge clk);
            if (took) i++;
        end
        if (!ended && i < n) begin
            errors++;
            checks++;
            $display("FAIL send timeout: got %0d bytes accepted, want %0d", i, n);
        end
        if (!hold) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            errors++;
            checks++;
            $display("FAIL idle timeout: got busy=%b after %0d cycles, want 0", busy, t);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        vecs[0] = '{"ramp60",   0, 60,  -1, 72};
        vecs[1] = '{"ascii9",   1, 9,   -1, PAD ? 72 : 21};
        vecs[2] = '{"one_ab",   2, 1,   -1, PAD ? 72 : 13};
        vecs[3] = '{"underrun", 0, 64,  20, 29};
        vecs[4] = '{"ramp100",  0, 100, -1, 112};
        vecs[5] = '{"rand59",   3, 59,  -1, PAD ? 72 : 71};
        vecs[6] = '{"rand61",   3, 61,  -1, 73};
        repeat (3) @(negedge clk);
        chk("reset tx_en", tx_en, 0);
        chk("reset tx_er", tx_er, 0);
        chk("reset tx_data", tx_data, 0);
        chk("reset s_ready", s_ready, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;
        foreach (vecs[v]) begin
            make_payload(vecs[v].kind, vecs[v].len);
            send(vecs[v].drop_at, -1, 1'b0, 1'b1, vecs[v].kind == 1 && !PAD);
            wait_idle();
            chk({vecs[v].name, " tx_en run"}, last_run, vecs[v].exp_run);
            chk({vecs[v].name, " leftover bytes"}, exp_q.size(), 0);
        end
        make_payload(0, 64);
        send(-1, -1, 1'b1, 1'b1, 1'b0);
        send(-1, -1, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("b2b ifg gap", last_gap, 12);
        chk("b2b tx_en run", last_run, 76);
        chk("b2b leftover bytes", exp_q.size(), 0);
        make_payload(0, 64);
        send(-1, 30, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("reset cut run", last_run, 38);
        make_payload(3, 60);
        send(-1, -1, 1'b0, 1'b1, 1'b0);
        wait_idle();
        chk("post-reset tx_en run", last_run, 72);
        chk("post-reset leftover bytes", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Byte-wide Ethernet MAC transmit framer. It accepts frame bytes (destination MAC through end of payload) on a valid/ready stream and emits a complete wire frame toward the PHY-side byte interface: preamble, SFD, data, zero padding to minimum length, FCS, then enforced inter-frame gap. The FCS is computed by an internal instance of the team's byte-wide `eth_crc32` engine.

## Interface
Parameters:
- `MIN_LEN`, default 60: minimum bytes between SFD and FCS; shorter frames are zero-padded.
- `IFG_LEN`, default 12: idle cycles (`tx_en`=0) after the last FCS byte.

Ports:
- `clk`  in  1  sole clock; one wire byte per cycle.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_data`  in  8  frame byte.
- `s_valid`  in  1  `s_data` valid.
- `s_last`  in  1  marks the final frame byte; qualified by `s_valid && s_ready`.
- `s_ready`  out  1  byte is taken at this edge.
- `tx_data`  out  8  wire byte, registered.
- `tx_en`  out  1  wire byte valid, registered.
- `tx_er`  out  1  abort marker, registered.
- `busy`  out  1  state != IDLE.

## Operation
- Reset: state IDLE. `tx_data`=0x00, `tx_en`=0, `tx_er`=0, `s_ready`=0, `busy`=0. CRC engine `rst` is driven with `!rst_n`.
- States and transitions:
  - IDLE: when `s_valid`=1, load 0x55 and go to PRE.
  - PRE: load 0x55 six more times (7 total), then load 0xD5 and go to SFD.
  - SFD: CRC engine is reset on this edge.
  - DATA: `s_ready`=1, combinational from state only.
    - Each edge with `s_valid`=1 loads `s_data` into `tx_data` and clocks it into the CRC engine.
    - Byte with `s_last`=1: go to PAD if count < `MIN_LEN`, else to FCS.
  - PAD: load 0x00 into `tx_data` and CRC until count = `MIN_LEN`, then go to FCS.
  - FCS: load ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24] in that order, then go to IFG. `crc` is the engine output, reflected bit order.
  - IFG: `tx_en`=0 for `IFG_LEN` cycles, then return to IDLE. `s_valid` is ignored during IFG.
- Byte count: 6-bit, saturating at `MIN_LEN`, cleared on entry to SFD. Frames have no maximum length.
- Underrun, i.e. `s_valid`=0 in DATA:
  - Load `tx_data`=0x00, `tx_en`=1, `tx_er`=1 for one cycle.
  - Go to IFG; no FCS is sent.
  - Source must discard the remainder of that frame. The next `s_valid` after IFG starts a new frame.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronous) and the frame is lost. The next frame starts with a full preamble.

## Timing
- `s_valid` rises in IDLE before edge 0:
  - `tx_en`=1 from cycle 1.
  - Preamble occupies cycles 1-7; SFD is on cycle 8.
  - `s_ready`=1 from cycle 8; first payload byte appears on cycle 9.
- Payload latency: one cycle from acceptance to `tx_data`.
- `tx_en` stays high for 8 + max(N, `MIN_LEN`) + 4 consecutive cycles, where N is the payload byte count.
- FCS byte 0 appears the cycle after the last data/pad byte, using the CRC state updated by that byte.
- Back-to-back frames: with `s_valid` held high, the next 0x55 appears exactly `IFG_LEN`+1 cycles after the last FCS byte (IFG, then IDLE detect).
- `tx_er` is never asserted together with FCS bytes.

## Configuration
- `ETH_TX_PAD_EN` defined: PAD state and padding behaviour as above.
- `ETH_TX_PAD_EN` undefined: PAD state removed. `s_last` always goes directly to FCS, so short frames go out unpadded. The count register is absent and `MIN_LEN` is unused.

## Test plan
- 60-byte frame with bytes 0x00..0x3B -> 72 `tx_en` cycles: 7×0x55, 0xD5, data, 4 FCS bytes matching a software CRC-32 of the 60 bytes.
- Padding disabled, payload ASCII "123456789" -> 21 `tx_en` cycles, FCS bytes 0x26 0x39 0xF4 0xCB.
- Padding enabled, 1-byte payload 0xAB -> 0xAB followed by 59×0x00, FCS over those 60 bytes, 72 `tx_en` cycles.
- Two 64-byte frames with `s_valid` held -> exactly 12 cycles with `tx_en`=0 between the last FCS byte and the next 0x55.
- `s_valid` dropped at payload byte 20 -> one cycle with `tx_en`=1, `tx_er`=1, `tx_data`=0x00, no FCS, then IFG. The next frame is correct.
- `rst_n` asserted low during payload byte 30 -> `tx_en`, `tx_er`, `s_ready` and `busy` go low without waiting for a clock edge. After release, the next frame has correct preamble and FCS.
